// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// one iteration per cycle, with results held in HI/LO until the next operation finishes.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

    state_t                  state;
    logic                    op_q;
    logic                    neg_q;
    logic                    neg_r;
    logic signed [WIDTH-1:0] mcand;
    logic [2*WIDTH:0]        prod;
    logic [WIDTH:0]          rem;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        dvs;
    logic [CNT_W-1:0]        cnt;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return cond_neg(v, v[WIDTH-1]);
    endfunction

    // Booth step: the accumulator is widened by one bit so that adding or subtracting
    // the most negative multiplicand cannot corrupt the sign shifted in.
    logic signed [WIDTH:0] booth_acc;
    logic signed [WIDTH:0] mcand_ext;
    logic signed [WIDTH:0] booth_sum;

    assign booth_acc = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    assign mcand_ext = {mcand[WIDTH-1], mcand};

    always_comb begin
        booth_sum = booth_acc;
        case (prod[1:0])
            2'b01:   booth_sum = booth_acc + mcand_ext;
            2'b10:   booth_sum = booth_acc - mcand_ext;
            default: booth_sum = booth_acc;
        endcase
    end

    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;

    assign div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, dvs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mcand    <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_r <= a_in[WIDTH-1];
                        mcand <= b_in;
                        prod  <= {{WIDTH{1'b0}}, a_in, 1'b0};
                        rem   <= '0;
                        quo   <= mag(a_in);
                        dvs   <= mag(b_in);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= (op && (b_in == '0)) ? ZERO : RUN;
                    end
                end
                RUN: begin
                    if (op_q) begin
                        if (!div_trial[WIDTH]) begin
                            rem <= div_trial;
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= div_shift;
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        prod <= {booth_sum, prod[WIDTH:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (op_q) begin
                        lo_out <= cond_neg(quo, neg_q);
                        hi_out <= cond_neg(rem[WIDTH-1:0], neg_r);
                    end else begin
                        hi_out <= prod[2*WIDTH:WIDTH+1];
                        lo_out <= prod[WIDTH:1];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: multiply/divide results, latency, divide-by-zero,
// start handshake during busy/done, and asynchronous reset mid-operation.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse.
    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          n;
        int          busy_n;
        logic        stable;
        logic [31:0] ph;
        logic [31:0] pl;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        ph = hi_out; pl = lo_out;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = busy ? 1 : 0;
        stable = 1'b1;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_n++;
            if (!done && (hi_out !== ph || lo_out !== pl)) stable = 1'b0;
        end
        chk({tag, " latency"}, 32'(n), 32'd33);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
        chk({tag, " hilo_stable"}, {31'd0, stable}, 32'd1);
        chk({tag, " hi"}, hi_out, exp_hi);
        chk({tag, " lo"}, lo_out, exp_lo);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " div_zero"}, {31'd0, div_zero}, 32'd0);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin : main
        int   n;
        logic seen_done;

        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst hi", hi_out, 32'd0);
        chk("rst lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul 7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mul max^2", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
        run_op("mul min^2", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("mul 3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);

        // Divide by zero keeps HI/LO from the previous multiply.
        @(negedge clk);
        start = 1'b1; op = 1'b1; a_in = 32'd5; b_in = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("dz done", {31'd0, done}, 32'd1);
        chk("dz div_zero", {31'd0, div_zero}, 32'd1);
        chk("dz busy", {31'd0, busy}, 32'd0);
        chk("dz hi", hi_out, 32'd0);
        chk("dz lo", lo_out, 32'd12);
        @(posedge clk); #1;
        chk("dz done_pulse", {31'd0, done}, 32'd0);
        chk("dz div_zero_pulse", {31'd0, div_zero}, 32'd0);

        // Start at edge 10 is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 9) begin
                start = 1'b1; a_in = 32'd9; b_in = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        chk("ign latency", 32'(n), 32'd33);
        chk("ign hi", hi_out, 32'd0);
        chk("ign lo", lo_out, 32'd30);
        start = 1'b1; op = 1'b0; a_in = 32'hFFFFFFFF; b_in = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b done_clear", {31'd0, done}, 32'd0);
        chk("b2b busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b latency", 32'(n), 32'd33);
        chk("b2b hi", hi_out, 32'hFFFFFFFF);
        chk("b2b lo", lo_out, 32'hFFFFFFFB);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd100; b_in = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst done", {31'd0, done}, 32'd0);
        chk("arst div_zero", {31'd0, div_zero}, 32'd0);
        chk("arst hi", hi_out, 32'd0);
        chk("arst lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("arst no_done", {31'd0, seen_done}, 32'd0);

        run_op("mul 2x3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
